// File: rtl/debug_overlay_pkg.sv
// Shared definitions for the debug display blocks: scanner states,
// ASCII anchors for hex rendering and the widest supported hex field.
package debug_overlay_pkg;

  typedef enum logic {
    CAPTURE = 1'b0,
    SCAN    = 1'b1
  } scan_state_t;

  localparam logic [7:0] ASCII_ZERO       = 8'h30;
  localparam logic [7:0] ASCII_A          = 8'h41;
  localparam int         MAX_FIELD_DIGITS = 8;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational 4-bit to uppercase ASCII hex digit converter.
module hex_nibble_to_ascii
  import debug_overlay_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = ASCII_ZERO + {4'd0, nibble};
    end else begin
      ascii = ASCII_A + {4'd0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/debug_overlay_scanner.sv
// Sweeps every terminal cell once per frame, overlaying hex renderings of
// per-frame channel snapshots on top of the background ROM characters.
module debug_overlay_scanner
  import debug_overlay_pkg::*;
#(
  parameter int COLUMNS       = 80,
  parameter int ROWS          = 30,
  parameter int ADDRESS_WIDTH = 12,
  parameter int CHANNEL_COUNT = 8
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [CHANNEL_COUNT*32-1:0]            channelData,
  input  logic [CHANNEL_COUNT*ADDRESS_WIDTH-1:0] fieldStart,
  input  logic [CHANNEL_COUNT*4-1:0]             fieldDigits,
  input  logic                                   freeze,
  output logic [ADDRESS_WIDTH-1:0]               backgroundAddress,
  input  logic [7:0]                             backgroundCharacter,
  output logic [ADDRESS_WIDTH-1:0]               terminalAddress,
  output logic [7:0]                             terminalWriteData,
  output logic                                   shouldWriteTerminal,
  input  logic                                   terminalReady,
  output logic                                   frameDone
);

  localparam int CELLS = COLUMNS * ROWS;
  localparam logic [ADDRESS_WIDTH:0] CELL_COUNT = (ADDRESS_WIDTH+1)'(CELLS);
  localparam logic [ADDRESS_WIDTH:0] LAST_CELL  = (ADDRESS_WIDTH+1)'(CELLS - 1);
  localparam logic [ADDRESS_WIDTH:0] PTR_ONE    = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

  scan_state_t                       state_q, state_d;
  logic [ADDRESS_WIDTH:0]            ptr_q, ptr_d;
  logic [CHANNEL_COUNT-1:0][31:0]    snap_q, snap_d;
  logic [ADDRESS_WIDTH-1:0]          addr_q, addr_d;
  logic [7:0]                        data_q, data_d;
  logic                              valid_q, valid_d;
  logic                              frame_done;
  logic                              accept;

  logic [CHANNEL_COUNT-1:0][31:0]    snap_view;
  logic [CHANNEL_COUNT-1:0]          field_hit;
  logic [3:0]                        field_nibble [CHANNEL_COUNT];
  logic                              field_found;
  logic [3:0]                        field_nib;
  logic [7:0]                        hex_char;
  logic [7:0]                        cell_char;

  // Cell 0 is loaded on the CAPTURE edge itself, so it must see the value being captured.
  assign snap_view = (state_q == CAPTURE && !freeze) ? channelData : snap_q;

  for (genvar k = 0; k < CHANNEL_COUNT; k++) begin : g_field
    logic [3:0]             raw_digits;
    logic [3:0]             digits;
    logic [ADDRESS_WIDTH:0] start;
    logic [ADDRESS_WIDTH:0] stop;
    logic [2:0]             pos;

    assign raw_digits = fieldDigits[4*k +: 4];
    assign digits     = (raw_digits > 4'(MAX_FIELD_DIGITS)) ? 4'(MAX_FIELD_DIGITS) : raw_digits;
    assign start      = {1'b0, fieldStart[ADDRESS_WIDTH*k +: ADDRESS_WIDTH]};
    assign stop       = start + (ADDRESS_WIDTH+1)'(digits);
    assign pos        = 3'(digits - 4'd1) - ptr_q[2:0] + start[2:0];
    assign field_hit[k]    = (digits != 4'd0) && (ptr_q >= start) && (ptr_q < stop);
    assign field_nibble[k] = snap_view[k][{pos, 2'b00} +: 4];
  end

  always_comb begin
    field_found = 1'b0;
    field_nib   = 4'd0;
    for (int k = CHANNEL_COUNT - 1; k >= 0; k--) begin
      if (field_hit[k]) begin
        field_found = 1'b1;
        field_nib   = field_nibble[k];
      end
    end
  end

  hex_nibble_to_ascii u_hex (
    .nibble (field_nib),
    .ascii  (hex_char)
  );

  assign cell_char = field_found ? hex_char : backgroundCharacter;
  assign accept    = valid_q && terminalReady;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    snap_d     = snap_q;
    addr_d     = addr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    frame_done = 1'b0;
    case (state_q)
      CAPTURE: begin
        if (!freeze) begin
          snap_d = channelData;
        end
        addr_d  = ptr_q[ADDRESS_WIDTH-1:0];
        data_d  = cell_char;
        valid_d = 1'b1;
        ptr_d   = ptr_q + PTR_ONE;
        state_d = SCAN;
      end
      SCAN: begin
        if (accept && {1'b0, addr_q} == LAST_CELL) begin
          valid_d    = 1'b0;
          frame_done = 1'b1;
          ptr_d      = '0;
          state_d    = CAPTURE;
        end else if ((!valid_q || terminalReady) && ptr_q < CELL_COUNT) begin
          addr_d  = ptr_q[ADDRESS_WIDTH-1:0];
          data_d  = cell_char;
          valid_d = 1'b1;
          ptr_d   = ptr_q + PTR_ONE;
        end else if (accept) begin
          valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= CAPTURE;
      ptr_q   <= '0;
      snap_q  <= '0;
      addr_q  <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      snap_q  <= snap_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign backgroundAddress   = ptr_q[ADDRESS_WIDTH-1:0];
  assign terminalAddress     = addr_q;
  assign terminalWriteData   = data_q;
  assign shouldWriteTerminal = valid_q;
  assign frameDone           = frame_done;

endmodule

// File: tb/tb_debug_overlay_scanner.sv
// Directed bench for debug_overlay_scanner at default parameters (80x30, 8 channels).
module tb_debug_overlay_scanner;

  localparam int CELLS = 2400;
  localparam int AW    = 12;
  localparam int CH    = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [CH*32-1:0]  channelData;
  logic [CH*AW-1:0]  fieldStart;
  logic [CH*4-1:0]   fieldDigits;
  logic              freeze;
  logic [AW-1:0]     backgroundAddress;
  logic [7:0]        backgroundCharacter;
  logic [AW-1:0]     terminalAddress;
  logic [7:0]        terminalWriteData;
  logic              shouldWriteTerminal;
  logic              terminalReady;
  logic              frameDone;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int done_count = 0;
  int done_cycle = 0;
  int prev_done = 0;
  int zero_cycle = 0;
  int frame_writes = 0;
  int last_frame_writes = 0;
  int order_err = 0;
  int bg_bad;
  logic [AW-1:0] done_addr = '0;
  logic [AW-1:0] expect_next = '0;
  logic [7:0]    screen [CELLS];

  debug_overlay_scanner dut (
    .clock               (clock),
    .reset               (reset),
    .channelData         (channelData),
    .fieldStart          (fieldStart),
    .fieldDigits         (fieldDigits),
    .freeze              (freeze),
    .backgroundAddress   (backgroundAddress),
    .backgroundCharacter (backgroundCharacter),
    .terminalAddress     (terminalAddress),
    .terminalWriteData   (terminalWriteData),
    .shouldWriteTerminal (shouldWriteTerminal),
    .terminalReady       (terminalReady),
    .frameDone           (frameDone)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] bg(input int a);
    return 8'(8'h80 | (a & 127));
  endfunction

  function automatic logic [7:0] hexc(input logic [3:0] n);
    string hd;
    hd = "0123456789ABCDEF";
    return hd[int'(n)];
  endfunction

  assign backgroundCharacter = bg(int'(backgroundAddress));

  // Write monitor: records every accepted write, away from the rising edge.
  initial begin
    forever begin
      @(negedge clock);
      cycle++;
      if (reset) begin
        frame_writes = 0;
        expect_next  = '0;
      end else begin
        if (shouldWriteTerminal && terminalReady) begin
          if (terminalAddress != expect_next) order_err++;
          if (int'(terminalAddress) < CELLS) screen[terminalAddress] = terminalWriteData;
          if (terminalAddress == '0) zero_cycle = cycle;
          expect_next = (terminalAddress == 12'd2399) ? 12'd0 : terminalAddress + 12'd1;
          frame_writes++;
        end
        if (frameDone) begin
          done_count++;
          prev_done         = done_cycle;
          done_cycle        = cycle;
          done_addr         = terminalAddress;
          last_frame_writes = frame_writes;
          frame_writes      = 0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic checkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_count < target && n < 3000) begin
      tick();
      n++;
    end
    checkv("frame_done_arrives", 32'(done_count >= target), 32'd1);
  endtask

  task automatic wait_addr(input int a);
    int n = 0;
    while (!(shouldWriteTerminal && int'(terminalAddress) == a) && n < 3000) begin
      tick();
      n++;
    end
    checkv("reach_address", 32'(int'(terminalAddress)), 32'(a));
  endtask

  task automatic check_hex(input string tag, input int start, input int n, input logic [31:0] val);
    logic [31:0] sh;
    for (int i = 0; i < n; i++) begin
      sh = val >> (4 * (n - 1 - i));
      checkv(tag, 32'(screen[start + i]), 32'(hexc(sh[3:0])));
    end
  endtask

  task automatic set_field(input int k, input int start, input int digits, input logic [31:0] val);
    fieldStart[k*AW +: AW]  = AW'(start);
    fieldDigits[k*4 +: 4]   = 4'(digits);
    channelData[k*32 +: 32] = val;
  endtask

  initial begin
    reset         = 1'b1;
    channelData   = '0;
    fieldStart    = '0;
    fieldDigits   = '0;
    freeze        = 1'b0;
    terminalReady = 1'b1;
    for (int i = 0; i < CELLS; i++) screen[i] = 8'h00;
    tick();
    tick();
    checkv("reset_valid", 32'(shouldWriteTerminal), 32'd0);
    checkv("reset_addr", 32'(terminalAddress), 32'd0);
    checkv("reset_data", 32'(terminalWriteData), 32'd0);
    checkv("reset_frame_done", 32'(frameDone), 32'd0);
    checkv("reset_bg_addr", 32'(backgroundAddress), 32'd0);

    // Frame 1: background only
    reset = 1'b0;
    tick();
    checkv("first_valid", 32'(shouldWriteTerminal), 32'd1);
    checkv("first_addr", 32'(terminalAddress), 32'd0);
    checkv("first_data", 32'(terminalWriteData), 32'(bg(0)));
    checkv("first_bg_addr", 32'(backgroundAddress), 32'd1);
    wait_done(1);
    checkv("f1_done_addr", 32'(done_addr), 32'd2399);
    checkv("f1_writes", 32'(last_frame_writes), 32'd2400);
    bg_bad = 0;
    for (int i = 0; i < CELLS; i++) if (screen[i] !== bg(i)) bg_bad++;
    checkv("f1_background_cells_wrong", 32'(bg_bad), 32'd0);

    // Frame 2 configuration, applied during the CAPTURE cycle
    set_field(0, 246, 8, 32'h1234ABCD);
    set_field(1, 300, 2, 32'h0000001F);
    set_field(2, 100, 4, 32'h0000BEEF);
    set_field(3, 100, 6, 32'h00123456);
    set_field(4, 2396, 8, 32'h89ABCDEF);
    set_field(5, 0, 0, 32'hFFFFFFFF);
    tick();
    tick();
    tick();
    checkv("restart_gap", 32'(zero_cycle - done_cycle), 32'd2);
    checkv("f1_single_done", 32'(done_count), 32'd1);

    wait_addr(500);
    terminalReady = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      checkv("stall_valid", 32'(shouldWriteTerminal), 32'd1);
      checkv("stall_addr", 32'(terminalAddress), 32'd500);
      checkv("stall_data", 32'(terminalWriteData), 32'(bg(500)));
    end
    terminalReady = 1'b1;
    wait_done(2);
    checkv("f2_period_with_stall", 32'(done_cycle - prev_done), 32'd2404);
    checkv("f2_writes", 32'(last_frame_writes), 32'd2400);
    check_hex("f2_field0", 246, 8, 32'h1234ABCD);
    checkv("f2_cell245_bg", 32'(screen[245]), 32'(bg(245)));
    checkv("f2_cell254_bg", 32'(screen[254]), 32'(bg(254)));
    check_hex("f2_field1_2digit", 300, 2, 32'h0000001F);
    checkv("f2_cell302_bg", 32'(screen[302]), 32'(bg(302)));
    check_hex("f2_overlap_field2", 100, 4, 32'h0000BEEF);
    checkv("f2_field3_digit4", 32'(screen[104]), 32'h35);
    checkv("f2_field3_digit5", 32'(screen[105]), 32'h36);
    check_hex("f2_truncated_field4", 2396, 4, 32'h000089AB);
    checkv("f2_cell2395_bg", 32'(screen[2395]), 32'(bg(2395)));
    checkv("f2_no_wrap_cell0", 32'(screen[0]), 32'(bg(0)));
    checkv("f2_cell1_bg", 32'(screen[1]), 32'(bg(1)));

    // Frame 3: clamp digits to 8, change channel 0 mid-frame
    fieldDigits[1*4 +: 4] = 4'd12;
    for (int i = 0; i < 50; i++) tick();
    channelData[0 +: 32] = 32'hDEADBEEF;
    wait_done(3);
    checkv("f3_period", 32'(done_cycle - prev_done), 32'd2401);
    check_hex("f3_field0_coherent", 246, 8, 32'h1234ABCD);
    check_hex("f3_field1_clamped", 300, 8, 32'h0000001F);
    checkv("f3_cell308_bg", 32'(screen[308]), 32'(bg(308)));

    // Frame 4 shows the new value; freeze raised mid-frame
    for (int i = 0; i < 20; i++) tick();
    freeze = 1'b1;
    channelData[0 +: 32] = 32'h55667788;
    wait_done(4);
    check_hex("f4_field0_new", 246, 8, 32'hDEADBEEF);
    wait_done(5);
    check_hex("f5_field0_frozen", 246, 8, 32'hDEADBEEF);
    wait_done(6);
    check_hex("f6_field0_frozen", 246, 8, 32'hDEADBEEF);

    // Frame 7: reset mid-frame at cell 1000
    wait_addr(1000);
    reset = 1'b1;
    #1;
    checkv("midreset_valid", 32'(shouldWriteTerminal), 32'd0);
    checkv("midreset_addr", 32'(terminalAddress), 32'd0);
    checkv("midreset_data", 32'(terminalWriteData), 32'd0);
    checkv("midreset_frame_done", 32'(frameDone), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    checkv("postreset_valid", 32'(shouldWriteTerminal), 32'd1);
    checkv("postreset_addr", 32'(terminalAddress), 32'd0);
    wait_done(7);
    checkv("postreset_writes", 32'(last_frame_writes), 32'd2400);
    check_hex("postreset_snapshot_zero", 246, 8, 32'h00000000);
    checkv("order_errors", 32'(order_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_overlay_scanner.md
# debug_overlay_scanner

Parametrised successor to the fixed 80×30 pipeline debug display. It repeatedly sweeps every cell of a character terminal and writes one character per accepted cycle. Each cell shows either the background ROM character or a hex rendering of a live debug channel. Every channel is snapshotted once per frame, so one frame never mixes old and new values. Writes to the terminal RAM use a ready handshake, and the screen can be frozen. The block sits between the CPU debug taps and the terminal RAM.

## Interface
- COLUMNS, 80, characters per row
- ROWS, 30, rows per frame; cell count CELLS = COLUMNS*ROWS, max 4096
- ADDRESS_WIDTH, 12, terminal address width; must satisfy 2^ADDRESS_WIDTH ≥ CELLS
- CHANNEL_COUNT, 8, number of 32-bit debug channels, which is also the number of hex fields
- clock  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high
- channelData  input  CHANNEL_COUNT*32  channel k occupies bits [32k+31:32k]
- fieldStart  input  CHANNEL_COUNT*ADDRESS_WIDTH  cell address of the first (most significant) digit of field k; quasi-static
- fieldDigits  input  CHANNEL_COUNT*4  digit count of field k; 0 disables the field; values above 8 are clamped to 8
- freeze  input  1  while high, snapshots are not refreshed
- backgroundAddress  output  ADDRESS_WIDTH  combinational copy of the scan pointer, for the asynchronous background ROM
- backgroundCharacter  input  8  ROM data, valid in the same cycle as backgroundAddress
- terminalAddress  output  ADDRESS_WIDTH  registered write address
- terminalWriteData  output  8  registered write character
- shouldWriteTerminal  output  1  registered write-valid
- terminalReady  input  1  a write is accepted when shouldWriteTerminal && terminalReady
- frameDone  output  1  one-cycle pulse on the cycle the last cell (CELLS−1) is accepted

## Operation
- State machine with two states, CAPTURE and SCAN. Reset state is CAPTURE.
- CAPTURE lasts one cycle:
  - If freeze is low, every channelData word is copied into the snapshot registers.
  - If freeze is high, the snapshot registers are held.
  - The scan pointer is set to 0 and the state moves to SCAN.
  - shouldWriteTerminal is low.
- SCAN: the output stage is a 1-deep valid/ready register.
  - Whenever the stage is empty or being accepted, it loads {scan pointer, character(scan pointer)} with valid = 1, and the pointer increments.
  - After cell CELLS−1 is loaded, no further load happens.
  - When cell CELLS−1 is accepted: frameDone pulses, valid drops, and the state moves to CAPTURE.
- While the stage holds a write and terminalReady is low, terminalAddress, terminalWriteData and shouldWriteTerminal hold their values and the pointer holds.
- Character selection for cell a:
  - Cell a belongs to field k if fieldStart_k ≤ a < fieldStart_k + digits_k, where digits_k is the clamped digit count.
  - If several fields contain a, the lowest k wins.
  - The digit index is i = a − fieldStart_k. The nibble shown is snapshot_k[4*(digits_k−1−i)+3 -: 4]. So an n-digit field shows the low n nibbles of the channel, most significant nibble first.
  - Nibbles 0–9 map to ASCII 0x30–0x39; nibbles A–F map to uppercase ASCII 0x41–0x46.
  - If cell a belongs to no field, the character is backgroundCharacter.
- Field-extent arithmetic is done in ADDRESS_WIDTH+1 bits. A field running past CELLS−1 is simply truncated and never wraps to cell 0.
- freeze changes take effect at the next CAPTURE only; a frame in progress is unaffected.
- fieldStart and fieldDigits may change at any time; the change affects cells loaded afterwards.

## Timing
- Reset values:
  - terminalAddress = 0, terminalWriteData = 0x00, shouldWriteTerminal = 0, frameDone = 0
  - snapshots = 0, pointer = 0, state = CAPTURE
- Reset asserted mid-frame returns everything to the reset values immediately. The first write after reset is released is cell 0 of a new frame.
- After reset is released:
  - cycle 0 is CAPTURE;
  - shouldWriteTerminal rises on cycle 1 with terminalAddress = 0.
- Latency is one cycle from the pointer (and backgroundAddress) to the registered output.
- With terminalReady held high, one cell is written per cycle and the frame period is CELLS + 1 cycles (one CAPTURE bubble).
- Each stall cycle (terminalReady low while valid) adds exactly one cycle to the frame.
- The snapshot is sampled on the CAPTURE clock edge. A channel change after that edge is not shown until the next frame.

## Structure
- Shared package `debug_overlay_pkg`:
  - state encoding (CAPTURE, SCAN);
  - ASCII constants for '0' and 'A';
  - maximum field width of 8 digits.
- Sub-module `hex_nibble_to_ascii`: a 4-bit to 8-bit combinational converter, reused by the other debug display blocks.
- Field matching is a generate loop over CHANNEL_COUNT followed by a lowest-index priority encoder.

## Test plan
- Default parameters, terminalReady held high, no fields enabled:
  - writes cover addresses 0..2399 in order, each carrying the background ROM value;
  - frameDone pulses exactly once, on address 2399;
  - the next write to address 0 comes 2 cycles after that pulse.
- Field 0 with fieldStart = 246 and fieldDigits = 8, channel 0 = 0x1234ABCD:
  - cells 246..253 receive "1234ABCD", i.e. 0x31 0x32 0x33 0x34 0x41 0x42 0x43 0x44;
  - cell 245 and cell 254 receive the background value.
- Field 1 with fieldDigits = 2, channel 1 = 0x0000001F: the two cells show "1F". Setting fieldDigits = 12 shows 8 digits, "0000001F".
- Overlapping fields: fields 2 and 3 both start at cell 100. Cell 100 shows the field 2 digit.
- Handshake: drop terminalReady for 3 cycles while cell 500 is valid:
  - address and data hold for those cycles;
  - no cell is skipped or duplicated;
  - the frame ends 3 cycles later than without the stall.
- Coherence and freeze:
  - change channel 0 in the middle of a frame: no change is visible until the next frame;
  - with freeze high, the value stays at the old snapshot across 2 frames.
- Reset pulse at cell 1000: the outputs go to 0 immediately, and the first write after reset is released is cell 0.
